// File: rtl/m_pkg.sv
// Shared types and default sizing for the m_restore restore adder.
package m_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_SHIFT = 2;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

endpackage

// File: rtl/fa1.sv
// One-bit full adder cell used for the bit resolved on each ADD cycle.
module fa1 (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/m_restore.sv
// Bit-serial restore adder: {cout,value} = diff + ((p + cin) << SHIFT), one bit per cycle.
// Optional build macro M_RESTORE_SAT_EN saturates value to all ones when the final carry is set.
module m_restore
  import m_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHIFT = DEF_SHIFT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] diff,
  input  logic [1:0]       p,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] value,
  output logic             cout
);

  localparam int IW    = $clog2(WIDTH) + 1;
  localparam int NBITS = WIDTH - SHIFT;

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   idx;
  logic            carry;
  logic [1:0]      p_r;
  logic            accept;
  logic            last;
  logic [WIDTH-1:0] mask;
  logic            a_bit;
  logic            b_bit;
  logic            s_bit;
  logic            co_bit;

  assign accept = start && (state != ADD);
  assign last   = (idx == IW'(NBITS - 1));
  assign busy   = (state == ADD);
  assign done   = (state == DONE);

  // value doubles as the captured diff: bits above the index still hold the
  // operand, so the current bit is read back from value before it is replaced.
  assign mask  = WIDTH'(1) << (IW'(SHIFT) + idx);
  assign a_bit = |(value & mask);

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    b_bit = 1'b0;
    if (idx == IW'(0))      b_bit = p_r[0];
    else if (idx == IW'(1)) b_bit = p_r[1];
  end

  fa1 u_fa1 (
    .a  (a_bit),
    .b  (b_bit),
    .ci (carry),
    .s  (s_bit),
    .co (co_bit)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ADD;
      ADD:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? ADD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
      cout  <= 1'b0;
      carry <= 1'b0;
      idx   <= '0;
      p_r   <= '0;
    end else if (accept) begin
      value <= diff;
      p_r   <= p;
      carry <= cin;
      idx   <= '0;
      cout  <= 1'b0;
    end else if (state == ADD) begin
      value <= s_bit ? (value | mask) : (value & ~mask);
      carry <= co_bit;
      idx   <= idx + IW'(1);
      if (last) begin
        cout <= co_bit;
`ifdef M_RESTORE_SAT_EN
        if (co_bit) value <= '1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_m_restore.sv
// Self-checking bench for m_restore (WIDTH=4, SHIFT=2) with a cycle-level result model.
module tb_m_restore;

  localparam int W = 4;
  localparam int S = 2;
  localparam int N = W - S;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] diff;
  logic [1:0]   p;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] value;
  logic         cout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  m_restore #(.WIDTH(W), .SHIFT(S)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .diff  (diff),
    .p     (p),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .value (value),
    .cout  (cout)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] result_of(input int sum);
`ifdef M_RESTORE_SAT_EN
    if (sum[W]) return '1;
`endif
    return sum[W-1:0];
  endfunction

  // Model: an accepted operation keeps the unit busy for N cycles, then
  // shows its sum for one done cycle; the result holds until the next start.
  int           rem    = 0;
  logic         done_m = 1'b0;
  logic [W-1:0] m_val  = '0;
  logic         m_cout = 1'b0;
  int           pend   = 0;
  bit           chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      rem    <= 0;
      done_m <= 1'b0;
      m_val  <= '0;
      m_cout <= 1'b0;
    end else if (rem > 0) begin
      rem <= rem - 1;
      if (rem == 1) begin
        done_m <= 1'b1;
        m_cout <= pend[W];
        m_val  <= result_of(pend);
      end
    end else begin
      done_m <= 1'b0;
      if (start) begin
        rem  <= N;
        pend <= int'(diff) + (int'(p) << S) + (int'(cin) << S);
      end
    end
  end

  always @(negedge clk) begin
    int           k;
    logic [W-1:0] msk;
    if (chk_en) begin
      check("busy", busy, rem > 0);
      check("done", done, done_m);
      if (rem == 0) begin
        check("value", value, m_val);
        check("cout", cout, m_cout);
      end else begin
        k   = S + (N - rem);
        msk = W'((1 << k) - 1);
        check("value_resolved_bits", value & msk, W'(pend) & msk);
      end
    end
  end

  task automatic op(input logic [W-1:0] d, input logic [1:0] pp, input logic c,
                    input logic [W-1:0] ev, input logic ec, input string nm,
                    input bit scramble);
    int lat;
    @(negedge clk);
    diff = d; p = pp; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (scramble) begin
      diff = 4'b1111; p = ~pp; cin = ~c;
    end
    lat = 1;
    while (done !== 1'b1 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check({nm, "_latency"}, lat, 3);
    check({nm, "_value"}, value, ev);
    check({nm, "_cout"}, cout, ec);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int           cnt;
    logic [5:0]   bz;
    logic [W-1:0] sat_exp;

    rst = 1'b1; start = 1'b0; diff = '0; p = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_value", value, 0);
    check("rst_cout", cout, 0);
    chk_en = 1'b1;
    rst = 1'b0;

    op(4'b0011, 2'b01, 1'b0, 4'b0111, 1'b0, "basic", 1'b0);
`ifdef M_RESTORE_SAT_EN
    sat_exp = 4'b1111;
`else
    sat_exp = 4'b1100;
`endif
    op(4'b1100, 2'b11, 1'b1, sat_exp, 1'b1, "overflow", 1'b0);
    op(4'b1111, 2'b11, 1'b1, 4'b1111, 1'b1, "max", 1'b0);
    op(4'b0101, 2'b00, 1'b1, 4'b1001, 1'b0, "cin_only", 1'b0);
    op(4'b1010, 2'b00, 1'b0, 4'b1010, 1'b0, "zero_addend", 1'b0);
    op(4'b0010, 2'b01, 1'b1, 4'b1010, 1'b0, "captured", 1'b1);
    repeat (2) @(negedge clk);

    // start held high: back-to-back operations every N+1 cycles
    diff = 4'b0001; p = 2'b10; cin = 1'b0; start = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (done) begin
        cnt++;
        check("cont_value", value, 4'b1001);
        check("cont_busy_in_done", busy, 0);
      end
    end
    start = 1'b0;
    check("cont_done_count", cnt, 3);
    repeat (2) @(negedge clk);

    // reset in the first ADD cycle aborts the operation
    diff = 4'b0011; p = 2'b01; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_value", value, 0);
    check("abort_cout", cout, 0);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("abort_no_done", cnt, 0);

    // start during ADD is ignored
    diff = 4'b0100; p = 2'b01; cin = 1'b0; start = 1'b1;
    cnt = 0;
    bz  = '0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      bz[i-1] = busy;
      if (done) cnt++;
      if (i == 1) start = 1'b0;
      if (i == 2) start = 1'b1;
      if (i == 3) start = 1'b0;
    end
    check("ignore_done_count", cnt, 1);
    check("ignore_busy_pattern", bz, 6'b000011);
    check("ignore_value", value, 4'b1000);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
